mem_bus_master: RTL
===================

MEM_BUS_MASTER -- requirements
Module: mem_bus_master

Interface
REQ-001 Parameter DATA_W, 32, data and address width in bits.
REQ-002 Parameter READ_LAT, 1, memory read latency in cycles; legal range 1..7.
REQ-003 The clock SHALL be clk; reset SHALL be rst, synchronous and active-high.
REQ-004 Ports (name  direction  width  meaning):
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request offered
- req_ready  out  1  master can accept a request
- req_write  in  1  1 = store, 0 = load
- req_addr  in  DATA_W  byte address
- req_wdata  in  DATA_W  store data
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer takes response
- rsp_rdata  out  DATA_W  load data; 0 for stores and errors
- rsp_err  out  1  misaligned request, no memory access made
- mem_address  out  DATA_W  address toward Memory_Management
- mem_wdata  out  DATA_W  write data toward Memory_Management
- mem_wboolean  out  1  one-cycle write strobe toward Memory_Management
- mem_rdata  in  DATA_W  read data from Memory_Management
- txn_count  out  16  completed-transaction counter

Function
REQ-005 The FSM SHALL have the states IDLE, ACCESS, WAIT, and RESP.
REQ-006 req_ready SHALL be 1 only in IDLE; a request is accepted on the edge where req_valid and req_ready are both 1.
REQ-007 On acceptance with req_addr[1:0] != 0, the master SHALL go to RESP with rsp_err=1 and rsp_rdata=0, and SHALL leave mem_wboolean at 0.
REQ-008 On an aligned acceptance at edge N, during cycle N+1 (ACCESS) the master SHALL drive mem_address=req_addr and mem_wdata=req_wdata, and mem_wboolean=req_write.
REQ-009 mem_wboolean SHALL be 1 for exactly one cycle per store and 0 in every other state.
REQ-010 A store SHALL go ACCESS -> RESP, with rsp_valid first 1 in cycle N+2.
REQ-011 A load SHALL hold mem_address through ACCESS and WAIT.
REQ-012 A load SHALL sample mem_rdata at the edge ending cycle N+READ_LAT; for READ_LAT=1 this is the edge ending the ACCESS cycle.
REQ-013 For a load, the master SHALL spend READ_LAT-1 cycles in WAIT and then enter RESP, with rsp_valid first 1 in cycle N+READ_LAT+1.
REQ-014 In RESP, rsp_valid SHALL stay 1, and rsp_rdata and rsp_err SHALL stay stable, until rsp_ready=1.
REQ-015 The master SHALL leave RESP for IDLE on the edge with rsp_valid and rsp_ready both 1; there is no back-to-back acceptance in that same cycle.
REQ-016 txn_count SHALL increment by 1 on each response handshake, errors included, and SHALL wrap from 0xFFFF to 0.
REQ-017 mem_address and mem_wdata SHALL hold their last driven values outside ACCESS and WAIT.
REQ-018 req_* changes while not in IDLE SHALL have no effect, because the request is captured at acceptance.

Reset
REQ-019 When rst=1 at an edge, the FSM SHALL go to IDLE.
REQ-020 When rst=1 at an edge, rsp_valid, rsp_err, mem_wboolean, rsp_rdata, mem_address, mem_wdata, and txn_count SHALL all become 0.
REQ-021 Reset asserted mid-transaction, in any state, SHALL abort the transaction with no response and no further write strobe.
REQ-022 req_ready SHALL be 1 in the first cycle after rst deasserts.

Structure
REQ-023 Package mem_bus_pkg SHALL hold the state enum (IDLE, ACCESS, WAIT, RESP) and a localparam for the txn_count width (16).
REQ-024 The READ_LAT down-counter SHALL be a sub-module, mem_lat_counter (load, decrement, zero flag, 3 bits); everything else stays in mem_bus_master.

Verification
REQ-025 Reset behaviour: rst=1 for 2 cycles, then 0 -> all outputs are 0 and req_ready=1 in the next cycle.
REQ-026 Store: write 0xDEADBEEF to 0x100 with rsp_ready=1 -> mem_wboolean=1 for exactly 1 cycle with mem_address=0x100, then rsp_valid=1, rsp_err=0, rsp_rdata=0, and txn_count=1.
REQ-027 Load at READ_LAT=1 and READ_LAT=3: read 0x004 with the model returning 0x12345678 -> rsp_valid first 1 at N+2 and N+4 respectively, with rsp_rdata=0x12345678.
REQ-028 Misaligned: read at 0x102 -> no mem_wboolean, rsp_err=1, rsp_rdata=0, and txn_count increments.
REQ-029 Back-pressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and data are held and req_ready=0; on release, one handshake occurs and the FSM returns to IDLE.
REQ-030 Abort and wrap: assert rst during WAIT -> no response is produced. Separately, preload txn_count to 0xFFFF by issuing 65535 transactions, then issue one more -> txn_count=0.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared types and constants for the memory bus master.
//   state_t  : request FSM encoding (IDLE, ACCESS, WAIT, RESP)
//   TXN_W    : width of the completed-transaction counter
//   LAT_W    : width of the read-latency down-counter (covers READ_LAT 1..7)
package mem_bus_pkg;

  localparam int TXN_W = 16;
  localparam int LAT_W = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  // Aligned means a word address: the two low byte-offset bits are clear.
  function automatic logic is_aligned(input logic [1:0] lsb);
    return lsb == 2'b00;
  endfunction

endpackage

// File: rtl/mem_lat_counter.sv
// mem_lat_counter: 3-bit down-counter used to time the read latency.
//   clk, rst  : clock, synchronous active-high reset (clears count)
//   load      : load load_val (has priority over dec)
//   load_val  : value to load
//   dec       : decrement by one; holds at zero
//   zero      : count is zero
module mem_lat_counter
  import mem_bus_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [LAT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [LAT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst)
      cnt_q <= '0;
    else if (load)
      cnt_q <= load_val;
    else if (dec && (cnt_q != '0))
      cnt_q <= cnt_q - 1'b1;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/mem_bus_master.sv
// mem_bus_master: single-outstanding request master toward Memory_Management.
// Accepts one load/store in IDLE, issues it for one ACCESS cycle (plus
// READ_LAT-1 WAIT cycles for loads), then holds the response in RESP until
// the consumer takes it. Misaligned requests skip the memory and respond with
// an error.
//   Parameters : DATA_W  data/address width
//                READ_LAT memory read latency in cycles, 1..7
//   Request    : req_valid/req_ready handshake, req_write, req_addr, req_wdata
//   Response   : rsp_valid/rsp_ready handshake, rsp_rdata, rsp_err
//   Memory     : mem_address, mem_wdata, mem_wboolean (write strobe), mem_rdata
//   Status     : txn_count, completed response handshakes (wraps)
module mem_bus_master
  import mem_bus_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [DATA_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [DATA_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wboolean,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       txn_count
);

  // Counter preload: ACCESS already accounts for one latency cycle.
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(READ_LAT - 1);

  state_t            state_q, state_d;
  logic              wr_q;
  logic [TXN_W-1:0]  txn_q;
  logic              accept;
  logic              aligned;
  logic              lat_load;
  logic              lat_dec;
  logic              lat_zero;
  logic              mem_done;
  logic              rsp_hs;

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign accept    = req_ready && req_valid;
  assign aligned   = is_aligned(req_addr[1:0]);
  assign rsp_hs    = rsp_valid && rsp_ready;
  assign txn_count = txn_q;

  mem_lat_counter u_lat (
    .clk      (clk),
    .rst      (rst),
    .load     (lat_load),
    .load_val (LAT_INIT),
    .dec      (lat_dec),
    .zero     (lat_zero)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // Next state and latency-counter control
  always_comb begin
    state_d  = state_q;
    lat_load = 1'b0;
    lat_dec  = 1'b0;
    mem_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          lat_load = 1'b1;
          state_d  = aligned ? ACCESS : RESP;
        end
      end
      ACCESS: begin
        // Stores complete in one cycle; loads with READ_LAT=1 sample here.
        if (wr_q || lat_zero) begin
          mem_done = 1'b1;
          state_d  = RESP;
        end else begin
          lat_dec = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (lat_zero) begin
          mem_done = 1'b1;
          state_d  = RESP;
        end else begin
          lat_dec = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: request capture, memory drive, response registers, counter.
  // The memory address/data registers only load on an aligned acceptance,
  // so they keep their last values everywhere outside ACCESS/WAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q         <= 1'b0;
      mem_address  <= '0;
      mem_wdata    <= '0;
      mem_wboolean <= 1'b0;
      rsp_rdata    <= '0;
      rsp_err      <= 1'b0;
      txn_q        <= '0;
    end else begin
      mem_wboolean <= 1'b0;
      if (accept) begin
        wr_q <= req_write;
        if (aligned) begin
          mem_address  <= req_addr;
          mem_wdata    <= req_wdata;
          mem_wboolean <= req_write;
        end else begin
          rsp_err   <= 1'b1;
          rsp_rdata <= '0;
        end
      end
      if (mem_done) begin
        rsp_err   <= 1'b0;
        rsp_rdata <= wr_q ? '0 : mem_rdata;
      end
      if (rsp_hs)
        txn_q <= txn_q + 1'b1;
    end
  end

endmodule
